// File: rtl/dm_rx_ctrl_if.sv
// Byte stream from the receive controller to the framing/CRC logic.
// The master drives the byte and its valid flag; the slave returns ready.
interface dm_rx_ctrl_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/dm_rx_ctrl.sv
// Receive-side controller for the differential Manchester decoder.
// Generates the half-bit strobe, realigns it on line transitions, hunts for
// preamble and SFD, deserializes payload bytes and detects end of frame on silence.
module dm_rx_ctrl #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned PRE_LEN = 16,
    parameter logic [7:0]  SFD     = 8'hD5,
    parameter int unsigned IDLE_HB = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [DIV_W-1:0]   div,
    input  logic               rx_slew,
    input  logic               rx_ce,
    input  logic               rx_sdata,
    output logic               rx_ce2x,
    dm_rx_ctrl_if.master       m_bus,
    output logic               locked,
    output logic               frame_end,
    output logic               overrun
);

    localparam logic [7:0] PreLenW  = 8'(PRE_LEN);
    localparam logic [7:0] IdleHbW  = 8'(IDLE_HB);
    localparam logic [7:0] SfdLimit = 8'd24;

    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StSfd,
        StData
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_d_q;
    logic [7:0]       sil_q, sil_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [7:0]       scnt_q, scnt_d;
    logic [2:0]       bcnt_q, bcnt_d;
    logic [7:0]       win_q, win_d;
    logic [7:0]       sr_q, sr_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             frame_end_q, frame_end_d;
    logic             overrun_q, overrun_d;
    logic             byte_done;
    logic             silent;

    // Half-bit strobe is a pure decode of the divider register.
    assign rx_ce2x = enable & (cnt_q == div);
    assign silent  = (sil_q >= IdleHbW);

    // Divider: a slew recentres the count mid half-bit, overriding wrap/increment.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (rx_slew) begin
            cnt_d = div >> 1;
        end else if (cnt_q == div) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Receive state machine with silence detection and bit deserialization.
    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        win_d       = win_q;
        sr_d        = sr_q;
        sil_d       = sil_q;
        frame_end_d = 1'b0;
        byte_done   = 1'b0;

        // Silence counter saturates so a long gap cannot wrap back to "active".
        if (rx_slew) begin
            sil_d = '0;
        end else if (rx_ce2x && (sil_q != 8'hFF)) begin
            sil_d = sil_q + 8'd1;
        end

        if (!enable) begin
            state_d = StIdle;
            pcnt_d  = '0;
            scnt_d  = '0;
            bcnt_d  = '0;
            win_d   = '0;
            sr_d    = '0;
            sil_d   = '0;
        end else if (state_q == StIdle) begin
            state_d = StHunt;
        end else if (silent) begin
            // Silence wins over a bit sampled in the same cycle; partial byte is lost.
            state_d     = StHunt;
            pcnt_d      = '0;
            scnt_d      = '0;
            bcnt_d      = '0;
            sil_d       = '0;
            frame_end_d = (state_q == StData);
        end else if (ce_d_q) begin
            case (state_q)
                StHunt: begin
                    if (rx_sdata) begin
                        pcnt_d = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
                    end else begin
                        pcnt_d = '0;
                    end
                    if (pcnt_d >= PreLenW) begin
                        state_d = StSfd;
                        win_d   = '0;
                        scnt_d  = '0;
                    end
                end
                StSfd: begin
                    win_d  = {rx_sdata, win_q[7:1]};
                    scnt_d = scnt_q + 8'd1;
                    if (win_d == SFD) begin
                        state_d = StData;
                        bcnt_d  = '0;
                        sr_d    = '0;
                    end else if (scnt_d == SfdLimit) begin
                        state_d = StHunt;
                        pcnt_d  = '0;
                        scnt_d  = '0;
                    end
                end
                StData: begin
                    sr_d = {rx_sdata, sr_q[7:1]};
                    if (bcnt_q == 3'd7) begin
                        byte_done = 1'b1;
                        bcnt_d    = '0;
                    end else begin
                        bcnt_d = bcnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Byte hand-off: a held byte is never overwritten, a colliding byte is dropped.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        overrun_d = 1'b0;
        if (!enable) begin
            m_valid_d = 1'b0;
        end else if (byte_done) begin
            if (!m_valid_q || m_bus.m_ready) begin
                m_data_d  = sr_d;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (m_bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ce_d_q      <= 1'b0;
            sil_q       <= '0;
            pcnt_q      <= '0;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            win_q       <= '0;
            sr_q        <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_end_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ce_d_q      <= rx_ce;
            sil_q       <= sil_d;
            pcnt_q      <= pcnt_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            win_q       <= win_d;
            sr_q        <= sr_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_end_q <= frame_end_d;
            overrun_q   <= overrun_d;
        end
    end

    assign locked         = (state_q == StSfd) || (state_q == StData);
    assign frame_end      = frame_end_q;
    assign overrun        = overrun_q;
    assign m_bus.m_data   = m_data_q;
    assign m_bus.m_valid  = m_valid_q;

endmodule

// File: tb/tb_dm_rx_ctrl.sv
// Directed bench for dm_rx_ctrl: the bench plays the decoder, a scoreboard
// queue holds the bytes the consumer should see, in order.
module tb_dm_rx_ctrl;

    localparam int unsigned DIV_W = 16;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             enable   = 1'b0;
    logic [DIV_W-1:0] div      = 16'd4;
    logic             rx_slew  = 1'b0;
    logic             rx_ce    = 1'b0;
    logic             rx_sdata = 1'b0;
    logic             rx_ce2x;
    logic             locked;
    logic             frame_end;
    logic             overrun;

    dm_rx_ctrl_if bus ();

    int         checks   = 0;
    int         failures = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         got_cnt  = 0;
    int         n        = 0;
    int         fe_base  = 0;
    logic [7:0] exp_q[$];

    dm_rx_ctrl #(
        .DIV_W   (DIV_W),
        .PRE_LEN (16),
        .SFD     (8'hD5),
        .IDLE_HB (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .div       (div),
        .rx_slew   (rx_slew),
        .rx_ce     (rx_ce),
        .rx_sdata  (rx_sdata),
        .rx_ce2x   (rx_ce2x),
        .m_bus     (bus),
        .locked    (locked),
        .frame_end (frame_end),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, return 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (frame_end) fe_cnt++;
        if (overrun) ov_cnt++;
        if (bus.m_valid && bus.m_ready) begin
            got_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ce2x", 32'(rx_ce2x), 32'd0);
        check("rst_data", 32'(bus.m_data), 32'd0);
        check("rst_flags", 32'({bus.m_valid, locked, frame_end, overrun}), 32'd0);
        tick();
        tick();
        rst     = 1'b0;
        fe_cnt  = 0;
        ov_cnt  = 0;
        got_cnt = 0;
        exp_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx_ce   = 1'b1;
        rx_slew = 1'b1;
        tick();
        rx_ce    = 1'b0;
        rx_slew  = 1'b0;
        rx_sdata = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_ones(input int cnt);
        for (int i = 0; i < cnt; i++) send_bit(1'b1);
    endtask

    task automatic count_to_pulse(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!rx_ce2x && cyc < 50);
    endtask

    initial begin
        bus.m_ready = 1'b1;
        enable      = 1'b1;
        #1;
        check("reset_state", 32'({rx_ce2x, bus.m_valid, locked, frame_end, overrun}), 32'd0);
        check("reset_data", 32'(bus.m_data), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Free-running divider, div = 4.
        count_to_pulse(n);
        count_to_pulse(n);
        check("period_div4_a", 32'(n), 32'd5);
        count_to_pulse(n);
        check("period_div4_b", 32'(n), 32'd5);
        check("pre_rst_ce2x", 32'(rx_ce2x), 32'd1);
        do_reset();

        // Slew realignment, div = 9.
        div = 16'd9;
        count_to_pulse(n);
        tick();
        tick();
        rx_slew = 1'b1;
        tick();
        rx_slew = 1'b0;
        count_to_pulse(n);
        check("slew_realign", 32'(n), 32'd5);
        rx_slew = 1'b1;
        #1;
        check("slew_coincident_ce2x", 32'(rx_ce2x), 32'd1);
        tick();
        rx_slew = 1'b0;
        count_to_pulse(n);
        check("slew_coincident_next", 32'(n), 32'd5);

        // Full frame with consumer always ready.
        div = 16'd4;
        bus.m_ready = 1'b1;
        do_reset();
        send_ones(15);
        check("lock_after15", 32'(locked), 32'd0);
        send_bit(1'b1);
        check("lock_after16", 32'(locked), 32'd1);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hA5);
        send_byte(8'hD5);
        check("lock_in_data", 32'(locked), 32'd1);
        send_byte(8'h3C);
        check("byte_latency_valid", 32'(bus.m_valid), 32'd1);
        check("byte0_data", 32'(bus.m_data), 32'h3C);
        send_byte(8'hA5);
        check("byte1_data", 32'(bus.m_data), 32'hA5);
        repeat (100) tick();
        check("frame_end_once", 32'(fe_cnt), 32'd1);
        check("no_overrun", 32'(ov_cnt), 32'd0);
        check("bytes_delivered", 32'(got_cnt), 32'd2);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("unlock_on_silence", 32'(locked), 32'd0);

        // Same frame with consumer stalled: second byte is dropped.
        bus.m_ready = 1'b0;
        do_reset();
        exp_q.push_back(8'h3C);
        send_ones(16);
        send_byte(8'hD5);
        send_byte(8'h3C);
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        send_byte(8'hA5);
        tick();
        check("overrun_once", 32'(ov_cnt), 32'd1);
        check("stall_hold_data", 32'(bus.m_data), 32'h3C);
        check("stall_hold_valid", 32'(bus.m_valid), 32'd1);
        bus.m_ready = 1'b1;
        tick();
        check("stall_delivered", 32'(got_cnt), 32'd1);
        check("stall_valid_cleared", 32'(bus.m_valid), 32'd0);
        repeat (100) tick();
        check("stall_frame_end", 32'(fe_cnt), 32'd1);
        check("stall_sb_drained", 32'(exp_q.size()), 32'd0);

        // Broken preamble, then SFD timeout.
        do_reset();
        send_ones(10);
        check("short_pre_nolock", 32'(locked), 32'd0);
        send_bit(1'b0);
        send_ones(15);
        check("second_run_15", 32'(locked), 32'd0);
        send_bit(1'b1);
        check("second_run_lock", 32'(locked), 32'd1);
        for (int i = 0; i < 23; i++) send_bit(1'b0);
        check("sfd_23_zeros", 32'(locked), 32'd1);
        send_bit(1'b0);
        check("sfd_timeout", 32'(locked), 32'd0);

        // Enable dropped mid-byte with a byte held.
        bus.m_ready = 1'b0;
        do_reset();
        send_ones(16);
        send_byte(8'hD5);
        send_byte(8'h3C);
        check("en_pre_valid", 32'(bus.m_valid), 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        count_to_pulse(n);
        check("en_pre_ce2x", 32'(rx_ce2x), 32'd1);
        fe_base = fe_cnt;
        enable  = 1'b0;
        #1;
        check("en_low_ce2x", 32'(rx_ce2x), 32'd0);
        tick();
        enable = 1'b1;
        check("en_valid_cleared", 32'(bus.m_valid), 32'd0);
        check("en_unlocked", 32'(locked), 32'd0);
        repeat (3) tick();
        check("en_no_frame_end", 32'(fe_cnt - fe_base), 32'd0);
        send_ones(15);
        check("en_relock_15", 32'(locked), 32'd0);
        send_bit(1'b1);
        check("en_relock_16", 32'(locked), 32'd1);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
